// File: rtl/net_pkg.sv
// Shared definitions for the TX frame path: byte width, default frame limit
// and the arbiter state encoding.
package net_pkg;

    localparam int NET_BYTE_W        = 8;
    localparam int NET_MAX_FRAME_LEN = 1514;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_XFER  = 2'b01,
        ST_DRAIN = 2'b10
    } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin priority encoder. The search starts one above
// 'last' and wraps modulo P_N; the first set request wins.
module rr_pick #(
    parameter int P_N  = 3,
    parameter int P_IW = $clog2(P_N)
) (
    input  logic [P_N-1:0]  req,
    input  logic [P_IW-1:0] last,
    output logic [P_N-1:0]  onehot,
    output logic [P_IW-1:0] idx,
    output logic            any
);

    logic [P_IW:0]   w_sum;
    logic [P_IW-1:0] w_cand;

    // Walk the candidates in rotation order and latch onto the first requester.
    always_comb begin
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        w_sum  = '0;
        w_cand = '0;
        for (int k = 1; k <= P_N; k++) begin
            w_sum = {1'b0, last} + (P_IW+1)'(k);
            if (w_sum >= (P_IW+1)'(P_N)) begin
                w_sum = w_sum - (P_IW+1)'(P_N);
            end
            w_cand = w_sum[P_IW-1:0];
            if (!any && req[w_cand]) begin
                any            = 1'b1;
                onehot[w_cand] = 1'b1;
                idx            = w_cand;
            end
        end
    end

endmodule

// File: rtl/tx_frame_arbiter.sv
// Frame-granular round-robin arbiter in front of the TX FIFO write port.
// A granted requester owns the port from its sof byte to its eof byte;
// frames longer than P_MAX_LEN are cut with a forced eof and the remainder
// is drained from the requester without being written.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   ST_IDLE  | no owner; stray non-sof bytes are swallowed; pick next owner
//   ST_XFER  | owner's bytes pass straight through to the FIFO
//   ST_DRAIN | frame was truncated; owner's bytes discarded until its eof
module tx_frame_arbiter
    import net_pkg::*;
#(
    parameter int P_NUM_REQ = 3,
    parameter int P_MAX_LEN = NET_MAX_FRAME_LEN
) (
    input  logic                            sys_clk,
    input  logic                            sys_rst_n,
    input  logic [NET_BYTE_W*P_NUM_REQ-1:0] req_byte,
    input  logic [P_NUM_REQ-1:0]            req_vld,
    input  logic [P_NUM_REQ-1:0]            req_sof,
    input  logic [P_NUM_REQ-1:0]            req_eof,
    output logic [P_NUM_REQ-1:0]            req_rdy,
    output logic [NET_BYTE_W-1:0]           wr_byte,
    output logic                            wr_byte_vld,
    input  logic                            wr_byte_rdy,
    output logic                            wr_sof,
    output logic                            wr_eof,
    output logic [P_NUM_REQ-1:0]            grant,
    output logic                            busy,
    output logic                            frm_trunc
);

    localparam int LP_IW = $clog2(P_NUM_REQ);
    localparam int LP_CW = $clog2(P_MAX_LEN + 1);
    // Count value while the P_MAX_LEN-th byte is on offer.
    localparam logic [LP_CW-1:0] LP_LAST_CNT = LP_CW'(P_MAX_LEN - 1);

    arb_state_t             r_state;
    arb_state_t             w_state_nxt;
    logic [P_NUM_REQ-1:0]   r_grant;
    logic [LP_IW-1:0]       r_last;
    logic [LP_CW-1:0]       r_cnt;
    logic                   r_trunc;

    logic [P_NUM_REQ-1:0]   w_req;
    logic [P_NUM_REQ-1:0]   w_pick_onehot;
    logic [LP_IW-1:0]       w_pick_idx;
    logic                   w_pick_any;
    logic [NET_BYTE_W-1:0]  w_g_byte;
    logic                   w_g_vld;
    logic                   w_g_eof;
    logic                   w_at_limit;
    logic                   w_grant_load;
    logic                   w_cnt_inc;
    logic                   w_trunc_nxt;

    assign w_req      = req_vld & req_sof;
    assign w_g_byte   = req_byte[NET_BYTE_W*int'(r_last) +: NET_BYTE_W];
    assign w_g_vld    = req_vld[r_last];
    assign w_g_eof    = req_eof[r_last];
    assign w_at_limit = (r_cnt == LP_LAST_CNT);

    assign grant     = r_grant;
    assign busy      = (r_state != ST_IDLE);
    assign frm_trunc = r_trunc;

    rr_pick #(
        .P_N  (P_NUM_REQ),
        .P_IW (LP_IW)
    ) u_rr_pick (
        .req    (w_req),
        .last   (r_last),
        .onehot (w_pick_onehot),
        .idx    (w_pick_idx),
        .any    (w_pick_any)
    );

    // State register.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and the combinational byte path to the FIFO.
    always_comb begin
        w_state_nxt  = r_state;
        req_rdy      = '0;
        wr_byte      = '0;
        wr_byte_vld  = 1'b0;
        wr_sof       = 1'b0;
        wr_eof       = 1'b0;
        w_grant_load = 1'b0;
        w_cnt_inc    = 1'b0;
        w_trunc_nxt  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                req_rdy = req_vld & ~req_sof;
                if (w_pick_any) begin
                    w_grant_load = 1'b1;
                    w_state_nxt  = ST_XFER;
                end
            end
            ST_XFER: begin
                wr_byte         = w_g_byte;
                wr_byte_vld     = w_g_vld;
                // sof follows the byte position, not the requester's marker.
                wr_sof          = w_g_vld && (r_cnt == '0);
                wr_eof          = w_g_vld && (w_g_eof || w_at_limit);
                req_rdy[r_last] = wr_byte_rdy;
                if (w_g_vld && wr_byte_rdy) begin
                    w_cnt_inc = 1'b1;
                    if (w_g_eof) begin
                        w_state_nxt = ST_IDLE;
                    end else if (w_at_limit) begin
                        w_state_nxt = ST_DRAIN;
                        w_trunc_nxt = 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                req_rdy[r_last] = 1'b1;
                if (w_g_vld && w_g_eof) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Owner, rotation pointer, length counter and truncation pulse.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            r_grant <= '0;
            r_last  <= LP_IW'(P_NUM_REQ - 1);
            r_cnt   <= '0;
            r_trunc <= 1'b0;
        end else begin
            r_trunc <= w_trunc_nxt;
            if (w_grant_load) begin
                r_grant <= w_pick_onehot;
                r_last  <= w_pick_idx;
                r_cnt   <= '0;
            end else if (w_state_nxt == ST_IDLE) begin
                r_grant <= '0;
            end
            if (w_cnt_inc) begin
                r_cnt <= r_cnt + LP_CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_tx_frame_arbiter.sv
// Scoreboard bench for tx_frame_arbiter with three requesters and a 64-byte
// frame limit. Senders queue the bytes they expect to see written; a monitor
// pops and compares on every FIFO write and logs grant/busy/trunc events.
module tb_tx_frame_arbiter;

    localparam int N    = 3;
    localparam int MAXL = 64;

    typedef struct packed {
        logic [7:0] b;
        logic       s;
        logic       e;
    } exp_t;

    logic           sys_clk = 1'b0;
    logic           sys_rst_n;
    logic [8*N-1:0] req_byte;
    logic [N-1:0]   req_vld, req_sof, req_eof, req_rdy;
    logic [7:0]     wr_byte;
    logic           wr_byte_vld, wr_byte_rdy, wr_sof, wr_eof;
    logic [N-1:0]   grant;
    logic           busy, frm_trunc;

    logic [7:0] d_byte [N];
    logic       d_vld  [N];
    logic       d_sof  [N];
    logic       d_eof  [N];

    exp_t exp_q[$];
    int   grant_log[$];
    int   gap_log[$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int n_wr     = 0;
    int eof_wr_cyc = -100;
    int grant_cyc  = 0;
    int busy_fall_cyc = 0;
    int trunc_cnt  = 0;
    int trunc_cyc  = 0;
    int trunc_grant = 0;
    int sof_cyc     [N];
    int drv_eof_cyc [N];
    int acc_cnt     [N];
    bit bp_en = 1'b0;

    always #5 sys_clk = ~sys_clk;
    always @(posedge sys_clk) cyc <= cyc + 1;

    for (genvar gi = 0; gi < N; gi++) begin : g_pack
        assign req_byte[8*gi +: 8] = d_byte[gi];
        assign req_vld[gi]         = d_vld[gi];
        assign req_sof[gi]         = d_sof[gi];
        assign req_eof[gi]         = d_eof[gi];
    end

    tx_frame_arbiter #(
        .P_NUM_REQ (N),
        .P_MAX_LEN (MAXL)
    ) dut (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .req_byte    (req_byte),
        .req_vld     (req_vld),
        .req_sof     (req_sof),
        .req_eof     (req_eof),
        .req_rdy     (req_rdy),
        .wr_byte     (wr_byte),
        .wr_byte_vld (wr_byte_vld),
        .wr_byte_rdy (wr_byte_rdy),
        .wr_sof      (wr_sof),
        .wr_eof      (wr_eof),
        .grant       (grant),
        .busy        (busy),
        .frm_trunc   (frm_trunc)
    );

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: actual %0d required %0d", name, act, req);
        end
    endtask

    function automatic logic [7:0] pat(input int r, input int seed, input int i);
        return 8'((r * 61 + seed * 17 + i * 7 + 3) & 255);
    endfunction

    function automatic int glog(input int k);
        if (k < grant_log.size()) return grant_log[k];
        return -1;
    endfunction

    function automatic int gapl(input int k);
        if (k < gap_log.size()) return gap_log[k];
        return -1;
    endfunction

    // Expected FIFO writes for one frame: at most MAXL bytes, forced eof at MAXL.
    task automatic push_frame(input int r, input int len, input int seed, input int stop_at);
        int nw;
        exp_t e;
        nw = (len < MAXL) ? len : MAXL;
        if (stop_at < nw) nw = stop_at;
        for (int i = 0; i < nw; i++) begin
            e.b = pat(r, seed, i);
            e.s = (i == 0);
            e.e = (i == len - 1) || (i == MAXL - 1);
            exp_q.push_back(e);
        end
    endtask

    // Offer a frame on requester r; called and returns at posedge+1.
    task automatic send_frame(input int r, input int len, input int seed,
                              input int stop_at, input bit do_push, input bit mid_sof);
        int i;
        int guard;
        if (do_push) push_frame(r, len, seed, stop_at);
        i = 0;
        guard = 0;
        sof_cyc[r] = cyc;
        while (i < len && i < stop_at) begin
            d_byte[r] = pat(r, seed, i);
            d_vld[r]  = 1'b1;
            d_sof[r]  = (i == 0) || (mid_sof && i == 5);
            d_eof[r]  = (i == len - 1);
            @(negedge sys_clk);
            if (req_rdy[r]) begin
                acc_cnt[r]++;
                if (i == len - 1) drv_eof_cyc[r] = cyc;
                i++;
            end
            guard++;
            @(posedge sys_clk); #1;
            if (guard > 2000) begin
                check("sender_timeout_bytes_accepted", i, len);
                break;
            end
        end
        d_vld[r] = 1'b0;
        d_sof[r] = 1'b0;
        d_eof[r] = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_grant"},     int'(grant), 0);
        check({tag, "_busy"},      int'(busy), 0);
        check({tag, "_wr_vld"},    int'(wr_byte_vld), 0);
        check({tag, "_wr_sof"},    int'(wr_sof), 0);
        check({tag, "_wr_eof"},    int'(wr_eof), 0);
        check({tag, "_req_rdy"},   int'(req_rdy), 0);
        check({tag, "_frm_trunc"}, int'(frm_trunc), 0);
        check({tag, "_wr_byte"},   int'(wr_byte), 0);
    endtask

    // FIFO-side backpressure: always ready, or toggling when enabled.
    initial begin
        wr_byte_rdy = 1'b1;
        forever begin
            @(posedge sys_clk); #1;
            wr_byte_rdy = bp_en ? ~wr_byte_rdy : 1'b1;
        end
    end

    // Monitor: scoreboard compare on each write, plus event logging.
    initial begin
        logic [N-1:0] prev_grant;
        logic         prev_busy;
        exp_t         e;
        prev_grant = '0;
        prev_busy  = 1'b0;
        forever begin
            @(negedge sys_clk);
            if (wr_byte_vld && wr_byte_rdy) begin
                n_wr++;
                if (exp_q.size() == 0) begin
                    check("unexpected_write_byte", int'(wr_byte), -1);
                end else begin
                    e = exp_q.pop_front();
                    check("write_byte_sof_eof", int'({wr_byte, wr_sof, wr_eof}), int'(e));
                end
                if (wr_eof) eof_wr_cyc = cyc;
            end
            if (grant != '0 && prev_grant == '0) begin
                grant_log.push_back(int'(grant));
                gap_log.push_back(cyc - eof_wr_cyc);
                grant_cyc = cyc;
            end
            if (prev_busy && !busy) busy_fall_cyc = cyc;
            if (frm_trunc) begin
                trunc_cnt++;
                trunc_cyc   = cyc;
                trunc_grant = int'(grant);
            end
            prev_grant = grant;
            prev_busy  = busy;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    initial begin
        int b_wr, b_gl, b_tr, b_acc, stray_acc;
        for (int i = 0; i < N; i++) begin
            d_byte[i] = '0; d_vld[i] = 1'b0; d_sof[i] = 1'b0; d_eof[i] = 1'b0;
            acc_cnt[i] = 0; sof_cyc[i] = 0; drv_eof_cyc[i] = 0;
        end
        sys_rst_n = 1'b0;
        repeat (3) @(posedge sys_clk);
        @(negedge sys_clk);
        check_reset_outputs("reset");
        @(posedge sys_clk); #1;
        sys_rst_n = 1'b1;
        @(posedge sys_clk); #1;

        // Single 60-byte frame from requester 0.
        b_wr = n_wr; b_gl = grant_log.size();
        send_frame(0, 60, 1, 1000, 1'b1, 1'b0);
        repeat (3) @(posedge sys_clk); #1;
        check("single_writes", n_wr - b_wr, 60);
        check("single_grant", glog(b_gl), 1);
        check("single_grant_latency", grant_cyc - sof_cyc[0], 1);
        check("single_busy_drop_after_eof", busy_fall_cyc - eof_wr_cyc, 1);

        // Round-robin from reset with all three requesting.
        sys_rst_n = 1'b0;
        repeat (2) @(posedge sys_clk); #1;
        sys_rst_n = 1'b1;
        b_gl = grant_log.size();
        push_frame(0, 4, 2, 1000);
        push_frame(1, 5, 3, 1000);
        push_frame(2, 6, 4, 1000);
        push_frame(0, 3, 5, 1000);
        fork
            begin
                send_frame(0, 4, 2, 1000, 1'b0, 1'b0);
                send_frame(0, 3, 5, 1000, 1'b0, 1'b0);
            end
            send_frame(1, 5, 3, 1000, 1'b0, 1'b0);
            send_frame(2, 6, 4, 1000, 1'b0, 1'b0);
        join
        repeat (3) @(posedge sys_clk); #1;
        check("rr_grant0", glog(b_gl),     1);
        check("rr_grant1", glog(b_gl + 1), 2);
        check("rr_grant2", glog(b_gl + 2), 4);
        check("rr_grant3", glog(b_gl + 3), 1);
        check("rr_gap1", gapl(b_gl + 1), 2);
        check("rr_gap2", gapl(b_gl + 2), 2);
        check("rr_gap3", gapl(b_gl + 3), 2);

        // 64-byte frame under toggling backpressure, with a stray mid-frame sof.
        b_wr = n_wr; b_tr = trunc_cnt;
        bp_en = 1'b1;
        send_frame(1, 64, 6, 1000, 1'b1, 1'b1);
        bp_en = 1'b0;
        repeat (3) @(posedge sys_clk); #1;
        check("bp_writes", n_wr - b_wr, 64);
        check("bp_no_trunc", trunc_cnt - b_tr, 0);

        // 100-byte frame: 64 written, 36 drained.
        b_wr = n_wr; b_tr = trunc_cnt; b_acc = acc_cnt[2];
        send_frame(2, 100, 7, 1000, 1'b1, 1'b0);
        repeat (3) @(posedge sys_clk); #1;
        check("trunc_writes", n_wr - b_wr, 64);
        check("trunc_accepted", acc_cnt[2] - b_acc, 100);
        check("trunc_pulses", trunc_cnt - b_tr, 1);
        check("trunc_pulse_timing", trunc_cyc - eof_wr_cyc, 1);
        check("trunc_grant_held", trunc_grant, 4);
        check("trunc_busy_drop", busy_fall_cyc - drv_eof_cyc[2], 1);

        // Exactly P_MAX_LEN bytes ends normally.
        b_wr = n_wr; b_tr = trunc_cnt;
        send_frame(0, 64, 8, 1000, 1'b1, 1'b0);
        repeat (3) @(posedge sys_clk); #1;
        check("exact_writes", n_wr - b_wr, 64);
        check("exact_no_trunc", trunc_cnt - b_tr, 0);

        // Single-byte frame.
        b_wr = n_wr;
        send_frame(1, 1, 9, 1000, 1'b1, 1'b0);
        repeat (3) @(posedge sys_clk); #1;
        check("one_byte_writes", n_wr - b_wr, 1);

        // Stray non-sof bytes in IDLE are swallowed.
        b_wr = n_wr; b_gl = grant_log.size(); stray_acc = 0;
        for (int k = 0; k < 5; k++) begin
            d_byte[2] = 8'(8'hA0 + k);
            d_vld[2]  = 1'b1;
            d_sof[2]  = 1'b0;
            d_eof[2]  = 1'b0;
            @(negedge sys_clk);
            if (req_rdy[2]) stray_acc++;
            @(posedge sys_clk); #1;
        end
        d_vld[2] = 1'b0;
        repeat (2) @(posedge sys_clk); #1;
        check("stray_accepted", stray_acc, 5);
        check("stray_writes", n_wr - b_wr, 0);
        check("stray_no_grant", grant_log.size() - b_gl, 0);

        // Reset in the middle of requester 0's frame, then 0 and 1 compete.
        send_frame(0, 30, 10, 10, 1'b1, 1'b0);
        sys_rst_n = 1'b0;
        @(posedge sys_clk);
        @(negedge sys_clk);
        check_reset_outputs("midrst");
        @(posedge sys_clk); #1;
        sys_rst_n = 1'b1;
        b_gl = grant_log.size();
        push_frame(0, 3, 11, 1000);
        push_frame(1, 3, 12, 1000);
        fork
            send_frame(0, 3, 11, 1000, 1'b0, 1'b0);
            send_frame(1, 3, 12, 1000, 1'b0, 1'b0);
        join
        repeat (3) @(posedge sys_clk); #1;
        check("postrst_grant0", glog(b_gl),     1);
        check("postrst_grant1", glog(b_gl + 1), 2);

        repeat (3) @(posedge sys_clk); #1;
        check("scoreboard_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
